// File: rtl/time_set_pkg.sv
// Shared types, BCD limits and arithmetic for the time/alarm setting controller.
package time_set_pkg;

   // Editing FSM state encoding; also exported as the display blink code.
   typedef enum logic [2:0] {
      ST_RUN    = 3'd0,
      ST_SET_TH = 3'd1,
      ST_SET_TM = 3'd2,
      ST_SET_AH = 3'd3,
      ST_SET_AM = 3'd4
   } state_e;

   localparam logic [7:0] HR_MAX        = 8'h23;
   localparam logic [7:0] MIN_MAX       = 8'h59;
   localparam logic [7:0] ALARM_RST_HR  = 8'h06;
   localparam logic [7:0] ALARM_RST_MIN = 8'h00;

   // Packed-BCD increment wrapping to 00 past lim. Any out-of-range or
   // non-BCD operand also wraps to 00 so the result is always valid BCD.
   function automatic logic [7:0] bcd_inc_lim(input logic [7:0] v,
                                              input logic [7:0] lim);
      logic [7:0] r;
      if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v >= lim)) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stable-count debouncer -> one-cycle
// press pulse on the debounced rising edge only.
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   logic [1:0]  sync_q;
   logic [15:0] cnt_q,   cnt_d;
   logic        db_q,    db_d;
   logic        db_prev_q;
   logic        press_q;

   // Synchroniser, debounce state and edge-detect registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], btn_i};
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
         press_q   <= db_q & ~db_prev_q;
      end
   end

   // Count consecutive disagreeing samples; any agreeing sample restarts.
   always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync_q[1] != db_q) begin
         if (cnt_q == 16'(DB_CYCLES - 1)) begin
            db_d  = sync_q[1];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Mode/increment button controller for setting the clock time and the alarm.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode_in,
   input  logic       btn_inc_in,
   input  logic [7:0] cur_hr,
   input  logic [7:0] cur_min,
   output logic       load_time,
   output logic [7:0] load_hr,
   output logic [7:0] load_min,
   output logic [7:0] alarm_hr,
   output logic [7:0] alarm_min,
   output logic       alarm_en,
   output logic [2:0] edit_state
);

   logic mode_press;
   logic inc_press;

   state_e     state_q,     state_d;
   logic [7:0] edit_hr_q,   edit_hr_d;
   logic [7:0] edit_min_q,  edit_min_d;
   logic [7:0] alarm_hr_q,  alarm_hr_d;
   logic [7:0] alarm_min_q, alarm_min_d;
   logic       alarm_en_q,  alarm_en_d;
   logic       load_q,      load_d;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_mode_in),
      .press_o (mode_press)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
      .clk     (clk),
      .rst     (rst),
      .btn_i   (btn_inc_in),
      .press_o (inc_press)
   );

   // FSM state and all output-facing registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         edit_hr_q   <= '0;
         edit_min_q  <= '0;
         alarm_hr_q  <= ALARM_RST_HR;
         alarm_min_q <= ALARM_RST_MIN;
         alarm_en_q  <= 1'b0;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         edit_hr_q   <= edit_hr_d;
         edit_min_q  <= edit_min_d;
         alarm_hr_q  <= alarm_hr_d;
         alarm_min_q <= alarm_min_d;
         alarm_en_q  <= alarm_en_d;
         load_q      <= load_d;
      end
   end

   // Next state and register updates; a mode press always wins over inc.
   always_comb begin
      state_d     = state_q;
      edit_hr_d   = edit_hr_q;
      edit_min_d  = edit_min_q;
      alarm_hr_d  = alarm_hr_q;
      alarm_min_d = alarm_min_q;
      alarm_en_d  = alarm_en_q;
      load_d      = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mode_press) begin
               state_d    = ST_SET_TH;
               edit_hr_d  = cur_hr;
               edit_min_d = cur_min;
            end else if (inc_press) begin
               alarm_en_d = ~alarm_en_q;
            end
         end
         ST_SET_TH: begin
            if (mode_press) begin
               state_d = ST_SET_TM;
            end else if (inc_press) begin
               edit_hr_d = bcd_inc_lim(edit_hr_q, HR_MAX);
            end
         end
         ST_SET_TM: begin
            if (mode_press) begin
               state_d = ST_SET_AH;
               load_d  = 1'b1;
            end else if (inc_press) begin
               edit_min_d = bcd_inc_lim(edit_min_q, MIN_MAX);
            end
         end
         ST_SET_AH: begin
            if (mode_press) begin
               state_d = ST_SET_AM;
            end else if (inc_press) begin
               alarm_hr_d = bcd_inc_lim(alarm_hr_q, HR_MAX);
            end
         end
         ST_SET_AM: begin
            if (mode_press) begin
               state_d = ST_RUN;
            end else if (inc_press) begin
               alarm_min_d = bcd_inc_lim(alarm_min_q, MIN_MAX);
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign load_time  = load_q;
   assign load_hr    = edit_hr_q;
   assign load_min   = edit_min_q;
   assign alarm_hr   = alarm_hr_q;
   assign alarm_min  = alarm_min_q;
   assign alarm_en   = alarm_en_q;
   assign edit_state = state_q;

endmodule
